// File: rtl/apb_pkg.sv
// Definitions shared between the APB master and its completers.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } apb_state_e;

  localparam int unsigned APB_ADDR_W   = 8;
  localparam int unsigned APB_DATA_W   = 8;
  localparam int unsigned APB_MAX_WAIT = 15;
  // Wide enough to hold APB_MAX_WAIT.
  localparam int unsigned APB_CNT_W    = 4;

endpackage

// File: rtl/apb_mem_array.sv
// Byte-wide storage array: synchronous clear, one write port, one combinational read port.
// Out-of-range addresses never alias: writes are dropped and reads return zero.
module apb_mem_array import apb_pkg::*; #(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [IdxW-1:0]   widx;
  logic [IdxW-1:0]   ridx;
  logic              waddr_ok;
  logic              raddr_ok;

  assign widx     = waddr_i[IdxW-1:0];
  assign ridx     = raddr_i[IdxW-1:0];
  assign waddr_ok = ({1'b0, waddr_i} < DepthLim);
  assign raddr_ok = ({1'b0, raddr_i} < DepthLim);

  // Next array contents: one optional byte update.
  always_comb begin
    mem_d = mem_q;
    if (we_i && waddr_ok) begin
      mem_d[widx] = wdata_i;
    end
  end

  // Array storage with synchronous clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = raddr_ok ? mem_q[ridx] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer in front of a byte array: latched setup, programmable wait states,
// registered outputs and PSLVERR on addresses at or beyond DEPTH.
module apb_slave_mem import apb_pkg::*; #(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PSEL,
  input  logic              PEN,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR
);

  localparam logic [APB_CNT_W-1:0] WaitCnt  = APB_CNT_W'(WAIT_CYCLES);
  localparam logic [APB_CNT_W-1:0] CntOne   = APB_CNT_W'(1);
  localparam logic [ADDR_W:0]      DepthLim = (ADDR_W + 1)'(DEPTH);

  apb_state_e          state_q, state_d;
  logic [APB_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                pready_q, pready_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic                pslverr_q, pslverr_d;

  logic                mem_we;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic                setup_err;
  logic                go_resp;
  logic                acc_write;
  logic                acc_err;

  assign setup_err = ({1'b0, PADDR} >= DepthLim);

  apb_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .we_i    (mem_we),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Handshake FSM next state, latched transfer fields and next registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    mem_we    = 1'b0;
    rd_addr   = addr_q;
    acc_write = write_q;
    acc_err   = err_q;
    go_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // PEN without a preceding setup phase is ignored.
        if (PSEL && !PEN) begin
          addr_d  = PADDR;
          write_d = PWRITE;
          wdata_d = PWDATA;
          err_d   = setup_err;
          cnt_d   = WaitCnt;
          if (WaitCnt == '0) begin
            // Zero-wait: response is loaded on the setup edge, so use the live bus.
            go_resp   = 1'b1;
            rd_addr   = PADDR;
            acc_write = PWRITE;
            acc_err   = setup_err;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (PEN) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntOne) begin
            go_resp = 1'b1;
          end
        end
      end
      RESP: begin
        // Commit the write on the edge that closes the completing cycle.
        mem_we  = write_q && !err_q;
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_resp) begin
      state_d   = RESP;
      pready_d  = 1'b1;
      pslverr_d = acc_err;
      prdata_d  = (!acc_write && !acc_err) ? rd_data : '0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign PREADY  = pready_q;
  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three builds (1, 0 and 3 wait states) on a shared clock and reset.
module tb_apb_slave_mem;

  localparam int NI    = 3;
  localparam int DEPTH = 64;
  localparam int unsigned WC [NI] = '{1, 0, 3};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       psel   [NI];
  logic       pen    [NI];
  logic       pwrite [NI];
  logic [7:0] paddr  [NI];
  logic [7:0] pwdata [NI];
  logic       pready [NI];
  logic [7:0] prdata [NI];
  logic       pslverr[NI];

  // Reference contents: a plain byte array per build.
  logic [7:0] model [NI][256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_slave_mem #(
      .ADDR_W      (8),
      .DATA_W      (8),
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WC[g])
    ) u_dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .PSEL    (psel[g]),
      .PEN     (pen[g]),
      .PWRITE  (pwrite[g]),
      .PADDR   (paddr[g]),
      .PWDATA  (pwdata[g]),
      .PREADY  (pready[g]),
      .PRDATA  (prdata[g]),
      .PSLVERR (pslverr[g])
    );
  end

  task automatic clear_model();
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < 256; a++) model[k][a] = 8'h00;
    end
  endtask

  // One APB transfer as a well-behaved master; starts and ends 1 time unit after an edge.
  // ncyc counts setup through the PREADY cycle, -1 if PREADY never came.
  task automatic xfer(input int k, input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                      input bit scramble, output logic [7:0] rd, output logic err,
                      output int ncyc, output logic rdy_after);
    psel[k]   = 1'b1;
    pen[k]    = 1'b0;
    pwrite[k] = wr;
    paddr[k]  = addr;
    pwdata[k] = wd;
    @(posedge clk); #1;
    pen[k] = 1'b1;
    if (scramble) begin
      paddr[k]  = 8'($urandom);
      pwdata[k] = 8'($urandom);
      pwrite[k] = 1'($urandom);
    end
    ncyc = 2;
    while (pready[k] !== 1'b1 && ncyc < 24) begin
      @(posedge clk); #1;
      ncyc++;
    end
    if (pready[k] !== 1'b1) ncyc = -1;
    rd  = prdata[k];
    err = pslverr[k];
    @(posedge clk); #1;
    rdy_after = pready[k];
    psel[k]   = 1'b0;
    pen[k]    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      psel[k] = 1'b0; pen[k] = 1'b0; pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      total++;
      if (pready[k] !== 1'b0) begin
        bad++; $display("FAIL reset_pready k=%0d got=%b want=0", k, pready[k]);
      end
      total++;
      if (pslverr[k] !== 1'b0) begin
        bad++; $display("FAIL reset_pslverr k=%0d got=%b want=0", k, pslverr[k]);
      end
      total++;
      if (prdata[k] !== 8'h00) begin
        bad++; $display("FAIL reset_prdata k=%0d got=%h want=00", k, prdata[k]);
      end
    end
    clear_model();
    rst_n = 1'b1;
  endtask

  task automatic test_first_read();
    logic [7:0] rd; logic err; int n; logic ra;
    xfer(0, 1'b0, 8'h05, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (n !== 3) begin bad++; $display("FAIL first_read_cycles got=%0d want=3", n); end
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL first_read_data got=%h want=00", rd); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL first_read_err got=%b want=0", err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic err; int n1, n2; logic ra;
    for (int k = 0; k < NI; k++) begin
      xfer(k, 1'b1, 8'h10, 8'hA5, 1'b0, rd, err, n1, ra);
      model[k][8'h10] = 8'hA5;
      xfer(k, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, n2, ra);
      total++;
      if (n1 !== int'(WC[k]) + 2) begin
        bad++; $display("FAIL b2b_wr_cycles k=%0d got=%0d want=%0d", k, n1, WC[k] + 2);
      end
      total++;
      if (n2 !== int'(WC[k]) + 2) begin
        bad++; $display("FAIL b2b_rd_cycles k=%0d got=%0d want=%0d", k, n2, WC[k] + 2);
      end
      total++;
      if (rd !== model[k][8'h10]) begin
        bad++; $display("FAIL b2b_rd_data k=%0d got=%h want=%h", k, rd, model[k][8'h10]);
      end
    end
  endtask

  task automatic test_error();
    logic [7:0] rd; logic err; int n; logic ra;
    xfer(0, 1'b1, 8'h40, 8'h3C, 1'b0, rd, err, n, ra);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_wr_flag got=%b want=1", err); end
    xfer(0, 1'b0, 8'h40, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL err_rd_flag got=%b want=1", err); end
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL err_rd_data got=%h want=00", rd); end
    xfer(0, 1'b0, 8'h00, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (rd !== model[0][0] || err !== 1'b0) begin
      bad++; $display("FAIL err_addr0 got=%h/%b want=%h/0", rd, err, model[0][0]);
    end
    // Last legal byte must still work.
    xfer(0, 1'b1, 8'h3F, 8'h5A, 1'b0, rd, err, n, ra);
    model[0][8'h3F] = 8'h5A;
    xfer(0, 1'b0, 8'h3F, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (rd !== 8'h5A || err !== 1'b0) begin
      bad++; $display("FAIL err_edge_3f got=%h/%b want=5a/0", rd, err);
    end
  endtask

  task automatic test_wait_builds();
    logic [7:0] rd; logic err; int n; logic ra;
    xfer(1, 1'b1, 8'h3F, 8'h77, 1'b0, rd, err, n, ra);
    model[1][8'h3F] = 8'h77;
    xfer(1, 1'b0, 8'h3F, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (n !== 2) begin bad++; $display("FAIL wait0_cycles got=%0d want=2", n); end
    total++;
    if (rd !== 8'h77) begin bad++; $display("FAIL wait0_data got=%h want=77", rd); end
    xfer(2, 1'b0, 8'h3F, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (n !== 5) begin bad++; $display("FAIL wait3_cycles got=%0d want=5", n); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; logic err; int n; logic ra; int highs;
    for (int k = 0; k < NI; k += 2) begin
      highs = 0;
      psel[k] = 1'b1; pen[k] = 1'b0; pwrite[k] = 1'b1; paddr[k] = 8'h01; pwdata[k] = 8'hFF;
      @(posedge clk); #1;
      if (WC[k] > 1) begin
        pen[k] = 1'b1;
        if (pready[k] === 1'b1) highs++;
        @(posedge clk); #1;
      end
      psel[k] = 1'b0; pen[k] = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (pready[k] === 1'b1) highs++;
        @(posedge clk); #1;
      end
      total++;
      if (highs != 0) begin bad++; $display("FAIL abort_pready k=%0d got=%0d want=0", k, highs); end
      xfer(k, 1'b0, 8'h01, 8'h00, 1'b0, rd, err, n, ra);
      total++;
      if (rd !== model[k][8'h01] || n !== int'(WC[k]) + 2) begin
        bad++;
        $display("FAIL abort_readback k=%0d got=%h/%0d want=%h/%0d",
                 k, rd, n, model[k][8'h01], WC[k] + 2);
      end
    end
  endtask

  task automatic test_protocol_violation();
    logic [7:0] rd; logic err; int n; logic ra; int highs;
    for (int k = 0; k < NI; k++) begin
      highs = 0;
      psel[k] = 1'b1; pen[k] = 1'b1; pwrite[k] = 1'b0; paddr[k] = 8'h10;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk); #1;
        if (pready[k] === 1'b1) highs++;
      end
      total++;
      if (highs != 0) begin bad++; $display("FAIL penonly_pready k=%0d got=%0d want=0", k, highs); end
      xfer(k, 1'b0, 8'h10, 8'h00, 1'b0, rd, err, n, ra);
      total++;
      if (n !== int'(WC[k]) + 2 || rd !== model[k][8'h10]) begin
        bad++;
        $display("FAIL penonly_recover k=%0d got=%h/%0d want=%h/%0d",
                 k, rd, n, model[k][8'h10], WC[k] + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, a, d, exp_rd; logic err, wr, exp_err; int n; logic ra;
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < 60; t++) begin
        wr = 1'($urandom);
        a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 63));
        d  = 8'($urandom);
        exp_err = (int'(a) >= DEPTH);
        exp_rd  = (!wr && !exp_err) ? model[k][a] : 8'h00;
        xfer(k, wr, a, d, 1'($urandom), rd, err, n, ra);
        if (wr && !exp_err) model[k][a] = d;
        total++;
        if (err !== exp_err || rd !== exp_rd) begin
          bad++;
          $display("FAIL rand_resp k=%0d wr=%b a=%h got=%h/%b want=%h/%b",
                   k, wr, a, rd, err, exp_rd, exp_err);
        end
        total++;
        if (n !== int'(WC[k]) + 2 || ra !== 1'b0) begin
          bad++;
          $display("FAIL rand_timing k=%0d got=%0d/%b want=%0d/0", k, n, ra, WC[k] + 2);
        end
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  task automatic test_reset_in_resp();
    logic [7:0] rd; logic err; int n; logic ra;
    psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 8'h02; pwdata[0] = 8'h55;
    @(posedge clk); #1;
    pen[0] = 1'b1;
    @(posedge clk); #1;
    total++;
    if (pready[0] !== 1'b1) begin bad++; $display("FAIL rstresp_pready got=%b want=1", pready[0]); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (pready[0] !== 1'b0 || pslverr[0] !== 1'b0) begin
      bad++; $display("FAIL rstresp_outputs got=%b/%b want=0/0", pready[0], pslverr[0]);
    end
    rst_n = 1'b1;
    psel[0] = 1'b0; pen[0] = 1'b0;
    clear_model();
    xfer(0, 1'b0, 8'h02, 8'h00, 1'b0, rd, err, n, ra);
    total++;
    if (rd !== 8'h00 || n !== 3) begin
      bad++; $display("FAIL rstresp_readback got=%h/%0d want=00/3", rd, n);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_back_to_back();
    test_error();
    test_wait_builds();
    test_abort();
    test_protocol_violation();
    test_random();
    test_reset_in_resp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
